// File: rtl/seq_detect_pkg.sv
// Shared constants for the symbol-sequence detector.
//   - Detector state codes S0..S3 (S3 = full 1->2->3 sequence seen, sticky).
//   - Symbol codes SYM_0..SYM_3 as carried on the 2-bit per-channel symbol lanes.
package seq_detect_pkg;

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    localparam logic [1:0] SYM_0 = 2'd0;
    localparam logic [1:0] SYM_1 = 2'd1;
    localparam logic [1:0] SYM_2 = 2'd2;
    localparam logic [1:0] SYM_3 = 2'd3;

endpackage

// File: rtl/seq_detect_arbiter_if.sv
// Requester/status bundle of the shared sequence detector.
//   req[NCH]   : channel i offers a symbol (held until granted)
//   sym[2*NCH] : per-channel 2-bit symbol lanes, sym[2i+1:2i] for channel i
//   clr[NCH]   : return channel i detector to S0
//   gnt[NCH]   : one-hot grant, symbol consumed on this edge
//   hit[NCH]   : channel i has seen 1->2->3 (sticky until clr/reset)
//   hit_any    : OR of hit
// master = symbol sources / status logic, slave = the detector.
interface seq_detect_arbiter_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0]   req;
    logic [2*NCH-1:0] sym;
    logic [NCH-1:0]   clr;
    logic [NCH-1:0]   gnt;
    logic [NCH-1:0]   hit;
    logic             hit_any;

    modport master (
        output req,
        output sym,
        output clr,
        input  gnt,
        input  hit,
        input  hit_any
    );

    modport slave (
        input  req,
        input  sym,
        input  clr,
        output gnt,
        output hit,
        output hit_any
    );
endinterface

// File: rtl/seq_step.sv
// Combinational next-state function of one 1->2->3 sequence detector.
//   state      : current detector state (S0..S3)
//   sym        : granted symbol
//   next_state : state after consuming sym
// S3 is absorbing; symbol 0 is a no-op.
module seq_step
    import seq_detect_pkg::*;
(
    input  logic [1:0] state,
    input  logic [1:0] sym,
    output logic [1:0] next_state
);

    always_comb begin
        next_state = state;
        if (state != S3) begin
            case (sym)
                SYM_1:   next_state = S1;
                SYM_2:   next_state = (state == S1) ? S2 : S0;
                SYM_3:   next_state = (state == S2) ? S3 : S0;
                default: next_state = state;
            endcase
        end
    end

endmodule

// File: rtl/seq_detect_arbiter.sv
// NCH requesters share one 1->2->3 sequence detection engine through a
// round-robin arbiter. Each channel keeps its own 2-bit detector state; the
// granted channel's symbol advances it, hit[i] is decoded from that register.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : seq_detect_arbiter_if.slave (req/sym/clr in, gnt/hit/hit_any out)
//   hit_cnt    : CNT_W*NCH saturating count of S2->S3 transitions per channel,
//                present only when macro HIT_CNT_EN is defined
module seq_detect_arbiter
    import seq_detect_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    seq_detect_arbiter_if.slave bus
`ifdef HIT_CNT_EN
    ,
    output logic [CNT_W*NCH-1:0] hit_cnt
`endif
);

    localparam int PTR_W = $clog2(NCH);

    if (NCH < 2 || NCH > 8 || CNT_W < 1) begin : g_bad_cfg
        $error("seq_detect_arbiter: NCH must be 2..8 and CNT_W >= 1");
    end

    logic [PTR_W-1:0] ptr_reg;
    logic [NCH-1:0]   gnt_comb;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_found;
    logic [NCH-1:0]   hit_vec;

    // First requester at or after the pointer, wrapping modulo NCH.
    // Grants are suppressed during reset so no symbol is consumed then.
    always_comb begin
        logic [PTR_W-1:0] sel;
        gnt_comb  = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        sel       = '0;
        for (int k = 0; k < NCH; k++) begin
            sel = PTR_W'((int'(ptr_reg) + k) % NCH);
            if (!gnt_found && !reset && bus.req[sel]) begin
                gnt_found     = 1'b1;
                gnt_comb[sel] = 1'b1;
                gnt_idx       = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (gnt_found) begin
            ptr_reg <= (gnt_idx == PTR_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [1:0] state_reg;
            logic [1:0] step_next;

            seq_step u_step (
                .state      (state_reg),
                .sym        (bus.sym[2*gi +: 2]),
                .next_state (step_next)
            );

            // clr wins over a same-cycle grant: the grant still goes out
            // (the requester sees its symbol consumed) but it is discarded.
            always_ff @(posedge clk) begin
                if (reset || bus.clr[gi]) begin
                    state_reg <= S0;
                end else if (gnt_comb[gi]) begin
                    state_reg <= step_next;
                end
            end

            assign hit_vec[gi] = (state_reg == S3);

`ifdef HIT_CNT_EN
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (reset || bus.clr[gi]) begin
                    cnt_reg <= '0;
                end else if (gnt_comb[gi] && state_reg == S2 && step_next == S3
                             && cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign hit_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
`endif
        end
    endgenerate

    assign bus.gnt     = gnt_comb;
    assign bus.hit     = hit_vec;
    assign bus.hit_any = |hit_vec;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed bench for seq_detect_arbiter (NCH=4). A driver applies one vector per
// cycle and queues the hand-computed gnt/hit for that cycle; a monitor on the
// falling edge pops and compares. hit_cnt (HIT_CNT_EN builds) is expected to be
// 1 exactly on channels that are in S3, since S3 is left only through clr/reset,
// both of which also zero the count.
module tb_seq_detect_arbiter;

    localparam int NCH   = 4;
    localparam int CNT_W = 2;

    typedef struct {
        int       cyc;
        logic [3:0] gnt;
        logic [3:0] hit;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    seq_detect_arbiter_if #(.NCH(NCH)) bus ();

`ifdef HIT_CNT_EN
    logic [CNT_W*NCH-1:0] hit_cnt;
`endif

    seq_detect_arbiter #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus)
`ifdef HIT_CNT_EN
        ,
        .hit_cnt (hit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mk(input logic [1:0] s0, input logic [1:0] s1,
                                      input logic [1:0] s2, input logic [1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic step(input logic rst, input logic [3:0] rq, input logic [7:0] sy,
                        input logic [3:0] cl, input logic [3:0] eg, input logic [3:0] eh);
        exp_t e;
        reset   = rst;
        bus.req = rq;
        bus.sym = sy;
        bus.clr = cl;
        e.cyc = cyc;
        e.gnt = eg;
        e.hit = eh;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation tagged for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                n_checks++;
                if (bus.gnt !== e.gnt) begin
                    n_fail++;
                    $display("FAIL gnt cyc=%0d actual=%b required=%b", e.cyc, bus.gnt, e.gnt);
                end
                n_checks++;
                if (bus.hit !== e.hit) begin
                    n_fail++;
                    $display("FAIL hit cyc=%0d actual=%b required=%b", e.cyc, bus.hit, e.hit);
                end
                n_checks++;
                if (bus.hit_any !== (|e.hit)) begin
                    n_fail++;
                    $display("FAIL hit_any cyc=%0d actual=%b required=%b", e.cyc, bus.hit_any, |e.hit);
                end
`ifdef HIT_CNT_EN
                begin
                    logic [CNT_W*NCH-1:0] exp_cnt;
                    exp_cnt = '0;
                    for (int i = 0; i < NCH; i++)
                        exp_cnt[i*CNT_W +: CNT_W] = e.hit[i] ? CNT_W'(1) : CNT_W'(0);
                    n_checks++;
                    if (hit_cnt !== exp_cnt) begin
                        n_fail++;
                        $display("FAIL hit_cnt cyc=%0d actual=%h required=%h", e.cyc, hit_cnt, exp_cnt);
                    end
                end
`endif
                $display("cyc %0d req=%b clr=%b gnt=%b hit=%b", e.cyc, bus.req, bus.clr, bus.gnt, bus.hit);
            end
        end
    end

    initial begin
        int wait_cnt;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.req  = 4'b1111;
        bus.sym  = 8'h00;
        bus.clr  = 4'b0000;
        @(posedge clk);
        #1;
        //   rst   req      sym              clr      gnt      hit
        // reset with all requests pending, then fairness sweep
        step(1, 4'b1111, 8'h00,          4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b1111, 8'h00,          4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b1111, 8'h00,          4'b0000, 4'b0001, 4'b0000);
        step(0, 4'b1111, 8'h00,          4'b0000, 4'b0010, 4'b0000);
        step(0, 4'b1111, 8'h00,          4'b0000, 4'b0100, 4'b0000);
        step(0, 4'b1111, 8'h00,          4'b0000, 4'b1000, 4'b0000);
        step(0, 4'b1111, 8'h00,          4'b0000, 4'b0001, 4'b0000);
        step(0, 4'b1111, 8'h00,          4'b0000, 4'b0010, 4'b0000);
        step(0, 4'b1111, 8'h00,          4'b0000, 4'b0100, 4'b0000);
        step(0, 4'b1111, 8'h00,          4'b0000, 4'b1000, 4'b0000);
        // ch0: 1,2,3 -> hit; a later 1 keeps it
        step(0, 4'b0001, mk(1,0,0,0),   4'b0000, 4'b0001, 4'b0000);
        step(0, 4'b0001, mk(2,0,0,0),   4'b0000, 4'b0001, 4'b0000);
        step(0, 4'b0001, mk(3,0,0,0),   4'b0000, 4'b0001, 4'b0000);
        step(0, 4'b0001, mk(1,0,0,0),   4'b0000, 4'b0001, 4'b0001);
        step(0, 4'b0000, 8'h00,          4'b0000, 4'b0000, 4'b0001);
        // ch1: 1,2,1,2,3
        step(0, 4'b0010, mk(0,1,0,0),   4'b0000, 4'b0010, 4'b0001);
        step(0, 4'b0010, mk(0,2,0,0),   4'b0000, 4'b0010, 4'b0001);
        step(0, 4'b0010, mk(0,1,0,0),   4'b0000, 4'b0010, 4'b0001);
        step(0, 4'b0010, mk(0,2,0,0),   4'b0000, 4'b0010, 4'b0001);
        step(0, 4'b0010, mk(0,3,0,0),   4'b0000, 4'b0010, 4'b0001);
        // clr without req, then 1,3 -> back to S0
        step(0, 4'b0000, 8'h00,          4'b0010, 4'b0000, 4'b0011);
        step(0, 4'b0010, mk(0,1,0,0),   4'b0000, 4'b0010, 4'b0001);
        step(0, 4'b0010, mk(0,3,0,0),   4'b0000, 4'b0010, 4'b0001);
        step(0, 4'b0000, 8'h00,          4'b0000, 4'b0000, 4'b0001);
        // move ptr to 1, then req=0101 -> 0100 then 0001
        step(0, 4'b0001, 8'h00,          4'b0000, 4'b0001, 4'b0001);
        step(0, 4'b0101, 8'h00,          4'b0000, 4'b0100, 4'b0001);
        step(0, 4'b0101, 8'h00,          4'b0000, 4'b0001, 4'b0001);
        // ch2 to S2, then clr races a granted 3
        step(0, 4'b0100, mk(0,0,1,0),   4'b0000, 4'b0100, 4'b0001);
        step(0, 4'b0100, mk(0,0,2,0),   4'b0000, 4'b0100, 4'b0001);
        step(0, 4'b0100, mk(0,0,3,0),   4'b0100, 4'b0100, 4'b0001);
        step(0, 4'b0000, 8'h00,          4'b0000, 4'b0000, 4'b0001);
        // ch3 partial 1,2 then reset mid-sequence
        step(0, 4'b1000, mk(0,0,0,1),   4'b0000, 4'b1000, 4'b0001);
        step(0, 4'b1000, mk(0,0,0,2),   4'b0000, 4'b1000, 4'b0001);
        step(1, 4'b1000, mk(0,0,0,3),   4'b0000, 4'b0000, 4'b0001);
        step(0, 4'b1000, mk(0,0,0,3),   4'b0000, 4'b1000, 4'b0000);
        step(0, 4'b1000, mk(0,0,0,1),   4'b0000, 4'b1000, 4'b0000);
        step(0, 4'b1000, mk(0,0,0,2),   4'b0000, 4'b1000, 4'b0000);
        step(0, 4'b1000, mk(0,0,0,3),   4'b0000, 4'b1000, 4'b0000);
        step(0, 4'b0000, 8'h00,          4'b0000, 4'b0000, 4'b1000);
        step(0, 4'b1000, mk(0,0,0,2),   4'b1000, 4'b1000, 4'b1000);
        step(0, 4'b0000, 8'h00,          4'b0000, 4'b0000, 4'b0000);
        // all channels request with mixed symbols
        step(0, 4'b1111, mk(1,1,1,1),   4'b0000, 4'b0001, 4'b0000);
        step(0, 4'b1111, mk(2,2,2,2),   4'b0000, 4'b0010, 4'b0000);
        step(0, 4'b1111, mk(2,2,2,2),   4'b0000, 4'b0100, 4'b0000);
        step(0, 4'b1111, mk(0,0,0,0),   4'b0000, 4'b1000, 4'b0000);
        step(0, 4'b0001, mk(2,0,0,0),   4'b0000, 4'b0001, 4'b0000);
        step(0, 4'b0001, mk(3,0,0,0),   4'b0000, 4'b0001, 4'b0000);
        step(0, 4'b0000, 8'h00,          4'b0000, 4'b0000, 4'b0001);

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL drain cyc=%0d actual=unchecked required=checked", e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
